// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Optional byte-lane stores are enabled by defining DMEM_STRB_EN.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

    localparam int WORD_BYTES = 4;
    localparam int WAIT_W     = 4;

    // Misaligned, below the window, or past its last byte; offset wraps harmlessly when addr < base.
    function automatic logic addr_fault(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span_bytes
    );
        logic [31:0] offset;
        offset = addr - base;
        return (addr[1:0] != 2'b00) || (addr < base) || (offset >= span_bytes);
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between an initiator and the data-memory responder.
// The be byte-enable lane exists only when DMEM_STRB_EN is defined.
interface dmem_if;

    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_STRB_EN
    logic [3:0]  be;
`endif
    logic        ready;
    logic [31:0] rdata;
    logic        err;

`ifdef DMEM_STRB_EN
    modport master (output req, we, addr, wdata, be, input ready, rdata, err);
    modport slave  (input req, we, addr, wdata, be, output ready, rdata, err);
`else
    modport master (output req, we, addr, wdata, input ready, rdata, err);
    modport slave  (input req, we, addr, wdata, output ready, rdata, err);
`endif

endinterface

// File: rtl/dmem_array.sv
// Word storage with synchronous write and combinational read; never cleared by reset.
// With DMEM_STRB_EN defined each byte lane is written only when its enable is set.
module dmem_array #(
    parameter int DEPTH_WORDS = 64,
    parameter int IDX_W       = 6
) (
    input  logic             clk,
    input  logic             wr_en,
`ifdef DMEM_STRB_EN
    input  logic [3:0]       wr_be,
`endif
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
`ifdef DMEM_STRB_EN
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
`else
            mem_q[wr_idx] <= wr_data;
`endif
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Slow-memory endpoint for the core's data bus: req/ready handshake, wait states, fault reporting.
// Define DMEM_STRB_EN to honour per-byte store enables.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic    clk,
    input  logic    reset,
    dmem_if.slave   bus
);

    localparam int                IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0]       SPAN_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [WAIT_W-1:0] WAIT_LOAD  = (WAIT_CYCLES > 0) ? WAIT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_t       state_q, state_d;
    logic [WAIT_W-1:0] cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              fault_q, fault_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef DMEM_STRB_EN
    logic [3:0]        be_q, be_d;
    logic [3:0]        acc_be;
`endif

    logic              live_fault;
    logic [IDX_W-1:0]  live_idx;
    logic              acc_we;
    logic              acc_fault;
    logic [IDX_W-1:0]  acc_idx;
    logic [31:0]       acc_wdata;
    logic              enter_resp;
    logic              mem_wr_en;
    logic [31:0]       mem_rd_data;

    assign live_fault = addr_fault(bus.addr, BASE_ADDR, SPAN_BYTES);
    assign live_idx   = IDX_W'((bus.addr - BASE_ADDR) >> 2);

    // With no wait states the access completes on the accept edge, so IDLE uses the live bus fields.
    assign acc_we    = (state_q == IDLE) ? bus.we     : we_q;
    assign acc_fault = (state_q == IDLE) ? live_fault : fault_q;
    assign acc_idx   = (state_q == IDLE) ? live_idx   : idx_q;
    assign acc_wdata = (state_q == IDLE) ? bus.wdata  : wdata_q;
`ifdef DMEM_STRB_EN
    assign acc_be    = (state_q == IDLE) ? bus.be     : be_q;
`endif

    assign mem_wr_en = enter_resp && acc_we && !acc_fault;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_wr_en),
`ifdef DMEM_STRB_EN
        .wr_be   (acc_be),
`endif
        .wr_idx  (acc_idx),
        .wr_data (acc_wdata),
        .rd_idx  (acc_idx),
        .rd_data (mem_rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        fault_d    = fault_q;
`ifdef DMEM_STRB_EN
        be_d       = be_q;
`endif
        ready_d    = 1'b0;
        err_d      = 1'b0;
        rdata_d    = rdata_q;
        enter_resp = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    idx_d   = live_idx;
                    wdata_d = bus.wdata;
                    fault_d = live_fault;
`ifdef DMEM_STRB_EN
                    be_d    = bus.be;
`endif
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LOAD;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response fields are captured on the same edge that writes the array.
        if (enter_resp) begin
            ready_d = 1'b1;
            err_d   = acc_fault;
            if (acc_fault) begin
                rdata_d = '0;
            end else if (!acc_we) begin
                rdata_d = mem_rd_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
`ifdef DMEM_STRB_EN
            be_q    <= '0;
`endif
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
`ifdef DMEM_STRB_EN
            be_q    <= be_d;
`endif
            ready_q <= ready_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the single-cycle ARM core's data bus. Serves word loads and stores issued by the core: the address comes from ALUResult, the store data from WriteData, and load data returns on ReadData.
- Adds a req/ready handshake with programmable wait states, plus alignment and range error reporting, so a stall-capable core or bus bridge can use it as the slow-memory endpoint.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; must be a power of 2.
- WAIT_CYCLES, 2, wait-state cycles between request accept and response; range 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to DEPTH_WORDS*4.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- req  input  1  initiator request valid; held high until ready.
- we  input  1  1 = store, 0 = load; stable while req is high.
- addr  input  32  byte address; stable while req is high.
- wdata  input  32  store data; stable while req is high.
- ready  output  1  one-cycle response strobe.
- rdata  output  32  load data; valid while ready is high.
- err  output  1  access fault; valid while ready is high.

Behaviour:
- Reset (reset=0, async): state=IDLE, ready=0, err=0, rdata=0, wait counter=0. Memory contents are not cleared. Reset asserted mid-access aborts it: no write, no response.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with req=1, latch we, addr, wdata and evaluate the fault check.
  - If WAIT_CYCLES>0, go to WAIT with counter=WAIT_CYCLES-1. Otherwise go straight to RESP.
- WAIT: decrement the counter each edge. At counter==0, go to RESP.
- RESP:
  - ready=1 for exactly one cycle, then IDLE. req is not sampled in RESP.
- Latency: ready is high in cycle N+WAIT_CYCLES+1, where the accept edge ends cycle N.
- Back-to-back: if req stays high after ready, the next request is accepted at the first IDLE edge. Throughput is one access per WAIT_CYCLES+2 cycles.
- Fault check:
  - err=1 if addr[1:0]!=0, or if addr is outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4-1].
  - On a fault: no write is performed and rdata=0.
- Word index: (addr-BASE_ADDR)>>2, truncated to $clog2(DEPTH_WORDS) bits after the range check.
- Store: memory is written on the edge entering RESP. rdata is unchanged on a store.
- Load: rdata is registered on the edge entering RESP and holds until the next load response or reset. A load after a store to the same word returns the new data.
- ready and err are registered outputs, 0 outside RESP.
- A req deassertion before ready is a protocol violation. The block completes the latched access regardless.

Optional Feature:
- Macro: DMEM_STRB_EN.
- Defined:
  - Adds port be (input, 4 bits, byte enables, stable while req is high).
  - A store writes only lanes with be[i]=1, where lane i = bits 8i+7:8i.
  - A store with be=0 completes with ready=1, err=0 and no memory change.
  - Loads ignore be.
- Undefined:
  - The port is absent; every store writes all 4 bytes.

Decomposition:
- Package dmem_pkg:
  - typedef enum logic [1:0] dmem_state_t {IDLE, WAIT, RESP}.
  - localparam WORD_BYTES=4.
  - localparam WAIT_W=4.
- Sub-module dmem_array:
  - DEPTH_WORDS x 32 storage with synchronous write (per-byte enable when DMEM_STRB_EN is defined) and combinational read.
  - Instantiated once in dmem_responder.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, keep req=0 for 10 cycles -> ready=0, err=0, rdata=0 throughout.
- Store then load (WAIT_CYCLES=2):
  - Store addr=0x10, wdata=0xDEADBEEF -> ready high exactly in cycle N+3, err=0.
  - Then load addr=0x10 -> ready in N'+3, rdata=0xDEADBEEF.
- Faults:
  - Load addr=0x13 -> ready with err=1, rdata=0.
  - Store addr=0x100 (DEPTH_WORDS=64) -> err=1.
  - A following load of 0x00 returns its prior contents, proving no write occurred.
- Back-to-back with WAIT_CYCLES=0:
  - Hold req=1 across 4 loads at 0x0/0x4/0x8/0xC -> ready every 2nd cycle, rdata in sequence.
- Reset mid-access:
  - Store 0x20=0x12345678.
  - Store 0x20=0xFFFFFFFF, asserting reset during WAIT -> no ready pulse.
  - After release, load 0x20 -> 0x12345678.
- DMEM_STRB_EN:
  - Store 0x8=0xAABBCCDD with be=4'b1111.
  - Store 0x8=0x11223344 with be=4'b0101.
  - Load 0x8 -> 0xAA22CC44.
